// File: rtl/led_bank.sv
// led_bank: per-channel LED driver (OFF / ON / BLINK / PWM) with a shared blink prescaler.
// Define LED_BANK_PWM_EN to build mode 11 as PWM; without it mode 11 behaves as ON.
module led_bank #(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 4,
  parameter int PWM_BITS = 4,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_wr_en,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [1:0]          i_wr_mode,
  input  logic [PWM_BITS-1:0] i_wr_duty,
  output logic [CHANNELS-1:0] o_led,
  output logic                o_tick,
  output logic                o_gnd
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  logic [CHANNELS-1:0][1:0] mode_q, mode_d;
  logic [PS_W-1:0]          presc_q, presc_d;
  logic                     tick_q, tick_d;
  logic                     blink_q, blink_d;
  logic [CHANNELS-1:0]      led_q, led_d;
  logic                     wrap_s;

`ifdef LED_BANK_PWM_EN
  logic [CHANNELS-1:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0]               pwm_q, pwm_d;
`else
  logic unused_duty;
  assign unused_duty = ^i_wr_duty;
`endif

  assign wrap_s = (presc_q == PS_MAX);

  // Channel configuration writes and shared counters; channels >= CHANNELS never match.
  always_comb begin
    mode_d = mode_q;
`ifdef LED_BANK_PWM_EN
    duty_d = duty_q;
    pwm_d  = pwm_q + 1'b1;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      if (i_wr_en && (i_wr_ch == CH_W'(c))) begin
        mode_d[c] = i_wr_mode;
`ifdef LED_BANK_PWM_EN
        duty_d[c] = i_wr_duty;
`endif
      end else begin
        mode_d[c] = mode_q[c];
      end
    end
    if (wrap_s) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    tick_d  = wrap_s;
    blink_d = blink_q ^ wrap_s;
  end

  // Per-channel LED decode from the state held before the edge.
  always_comb begin
    led_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_q[c])
        MODE_OFF:   led_d[c] = 1'b0;
        MODE_ON:    led_d[c] = 1'b1;
        MODE_BLINK: led_d[c] = blink_q;
        MODE_PWM: begin
`ifdef LED_BANK_PWM_EN
          led_d[c] = (pwm_q < duty_q[c]);
`else
          led_d[c] = 1'b1;
`endif
        end
        default:    led_d[c] = 1'b0;
      endcase
    end
  end

  // State registers; reset wins over a simultaneous write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mode_q  <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      blink_q <= 1'b0;
      led_q   <= '0;
`ifdef LED_BANK_PWM_EN
      duty_q  <= '0;
      pwm_q   <= '0;
`endif
    end else begin
      mode_q  <= mode_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      blink_q <= blink_d;
      led_q   <= led_d;
`ifdef LED_BANK_PWM_EN
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
`endif
    end
  end

  assign o_led  = led_q;
  assign o_tick = tick_q;
  assign o_gnd  = 1'b0;

endmodule

// File: tb/tb_led_bank.sv
// Directed bench for led_bank: a 4-channel and a 3-channel instance share one stimulus bus.
module tb_led_bank;

  logic       clk;
  logic       i_reset;
  logic       i_wr_en;
  logic [1:0] i_wr_ch;
  logic [1:0] i_wr_mode;
  logic [3:0] i_wr_duty;
  logic [3:0] led4;
  logic [2:0] led3;
  logic       tick4, tick3, gnd4, gnd3;

  int total;
  int bad;

  led_bank #(.CHANNELS(4), .PRESCALE(4), .PWM_BITS(4)) dut4 (
    .i_clock(clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch),
    .i_wr_mode(i_wr_mode), .i_wr_duty(i_wr_duty),
    .o_led(led4), .o_tick(tick4), .o_gnd(gnd4)
  );

  led_bank #(.CHANNELS(3), .PRESCALE(4), .PWM_BITS(4)) dut3 (
    .i_clock(clk), .i_reset(i_reset), .i_wr_en(i_wr_en), .i_wr_ch(i_wr_ch),
    .i_wr_mode(i_wr_mode), .i_wr_duty(i_wr_duty),
    .o_led(led3), .o_tick(tick3), .o_gnd(gnd3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One reset edge; counters are 0 afterwards and the next edge is "edge 1".
  task automatic do_reset();
    i_reset = 1'b1;
    i_wr_en = 1'b0;
    step();
    i_reset = 1'b0;
  endtask

  task automatic put_write(input logic [1:0] ch, input logic [1:0] mode, input logic [3:0] duty);
    i_wr_en   = 1'b1;
    i_wr_ch   = ch;
    i_wr_mode = mode;
    i_wr_duty = duty;
  endtask

  task automatic test_reset();
    logic e;
    i_reset = 1'b1;
    i_wr_en = 1'b0;
    step();
    step();
    total++; if (led4 !== 4'b0000) begin bad++; $display("FAIL reset_led4 got=%b exp=0000", led4); end
    total++; if (tick4 !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick4); end
    total++; if (gnd4 !== 1'b0) begin bad++; $display("FAIL reset_gnd got=%b exp=0", gnd4); end
    total++; if (led3 !== 3'b000) begin bad++; $display("FAIL reset_led3 got=%b exp=000", led3); end
    i_reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      e = ((k % 4) == 0);
      total++; if (tick4 !== e) begin bad++; $display("FAIL reset_tick_sched edge=%0d got=%b exp=%b", k, tick4, e); end
      total++; if (gnd4 !== 1'b0) begin bad++; $display("FAIL gnd edge=%0d got=%b exp=0", k, gnd4); end
    end
  endtask

  task automatic test_write_latency();
    do_reset();
    put_write(2'd1, 2'b01, 4'd0);
    step();
    i_wr_en = 1'b0;
    total++; if (led4 !== 4'b0000) begin bad++; $display("FAIL lat_edgeN got=%b exp=0000", led4); end
    step();
    total++; if (led4 !== 4'b0010) begin bad++; $display("FAIL lat_edgeN1 got=%b exp=0010", led4); end
    i_reset = 1'b1;
    put_write(2'd2, 2'b01, 4'd0);
    step();
    i_reset = 1'b0;
    i_wr_en = 1'b0;
    total++; if (led4 !== 4'b0000) begin bad++; $display("FAIL wr_rst_0 got=%b exp=0000", led4); end
    step();
    step();
    total++; if (led4 !== 4'b0000) begin bad++; $display("FAIL wr_rst_lost got=%b exp=0000", led4); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    put_write(2'd0, 2'b01, 4'd0);
    step();
    put_write(2'd2, 2'b01, 4'd0);
    step();
    total++; if (led4 !== 4'b0001) begin bad++; $display("FAIL b2b_1 got=%b exp=0001", led4); end
    put_write(2'd0, 2'b00, 4'd0);
    step();
    i_wr_en = 1'b0;
    total++; if (led4 !== 4'b0101) begin bad++; $display("FAIL b2b_2 got=%b exp=0101", led4); end
    step();
    total++; if (led4 !== 4'b0100) begin bad++; $display("FAIL b2b_3 got=%b exp=0100", led4); end
  endtask

  // Blink phase flips at the wrap edge, so o_led[0] follows one edge after o_tick.
  task automatic test_blink();
    logic e;
    do_reset();
    put_write(2'd0, 2'b10, 4'd0);
    step();
    i_wr_en = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      step();
      e = (((k - 1) / 4) % 2) == 1;
      total++; if (led4[0] !== e) begin bad++; $display("FAIL blink edge=%0d got=%b exp=%b", k, led4[0], e); end
      e = ((k % 4) == 0);
      total++; if (tick4 !== e) begin bad++; $display("FAIL blink_tick edge=%0d got=%b exp=%b", k, tick4, e); end
    end
  endtask

  task automatic test_pwm();
    int highs;
    logic e;
`ifdef LED_BANK_PWM_EN
    do_reset();
    put_write(2'd3, 2'b11, 4'd5);
    step();
    i_wr_en = 1'b0;
    highs = 0;
    for (int k = 2; k <= 17; k++) begin
      step();
      e = (((k - 1) % 16) < 5);
      if (led4[3] === 1'b1) highs++;
      total++; if (led4[3] !== e) begin bad++; $display("FAIL pwm5 edge=%0d got=%b exp=%b", k, led4[3], e); end
    end
    total++; if (highs != 5) begin bad++; $display("FAIL pwm5_count got=%0d exp=5", highs); end
    put_write(2'd3, 2'b11, 4'd0);
    step();
    i_wr_en = 1'b0;
    step();
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (led4[3] === 1'b1) highs++;
    end
    total++; if (highs != 0) begin bad++; $display("FAIL pwm0_count got=%0d exp=0", highs); end
    put_write(2'd3, 2'b11, 4'd15);
    step();
    i_wr_en = 1'b0;
    step();
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (led4[3] === 1'b1) highs++;
    end
    total++; if (highs != 15) begin bad++; $display("FAIL pwm15_count got=%0d exp=15", highs); end
`else
    do_reset();
    put_write(2'd3, 2'b11, 4'd5);
    step();
    i_wr_en = 1'b0;
    highs = 0;
    for (int k = 2; k <= 17; k++) begin
      step();
      if (led4[3] === 1'b1) highs++;
      total++; if (led4 !== 4'b1000) begin bad++; $display("FAIL mode11_on edge=%0d got=%b exp=1000", k, led4); end
    end
    e = (highs == 16);
    total++; if (e !== 1'b1) begin bad++; $display("FAIL mode11_count got=%0d exp=16", highs); end
`endif
  endtask

  task automatic test_boundary();
    logic e;
    do_reset();
    put_write(2'd3, 2'b01, 4'd0);
    step();
    i_wr_en = 1'b0;
    step();
    total++; if (led3 !== 3'b000) begin bad++; $display("FAIL oob_led3 got=%b exp=000", led3); end
    total++; if (led4 !== 4'b1000) begin bad++; $display("FAIL oob_led4 got=%b exp=1000", led4); end
    step();
    step();
    total++; if (tick3 !== 1'b1) begin bad++; $display("FAIL oob_tick got=%b exp=1", tick3); end
    total++; if (led3 !== 3'b000) begin bad++; $display("FAIL oob_led3_late got=%b exp=000", led3); end
    do_reset();
    put_write(2'd0, 2'b10, 4'd0);
    step();
    i_wr_en = 1'b0;
    for (int k = 2; k <= 6; k++) step();
    total++; if (led3 !== 3'b001) begin bad++; $display("FAIL midblink_pre got=%b exp=001", led3); end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    total++; if (led3 !== 3'b000) begin bad++; $display("FAIL midblink_rst got=%b exp=000", led3); end
    total++; if (tick3 !== 1'b0) begin bad++; $display("FAIL midblink_rst_tick got=%b exp=0", tick3); end
    for (int k = 1; k <= 8; k++) begin
      step();
      e = ((k % 4) == 0);
      total++; if (tick3 !== e) begin bad++; $display("FAIL midblink_tick edge=%0d got=%b exp=%b", k, tick3, e); end
      total++; if (led3 !== 3'b000) begin bad++; $display("FAIL midblink_off edge=%0d got=%b exp=000", k, led3); end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    i_reset   = 1'b1;
    i_wr_en   = 1'b0;
    i_wr_ch   = 2'd0;
    i_wr_mode = 2'b00;
    i_wr_duty = 4'd0;
    #2;
    test_reset();
    test_write_latency();
    test_back_to_back();
    test_blink();
    test_pwm();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
